// File: rtl/debouncer_bank.sv
// Multi-channel debouncer: per-channel stability counter against a shared runtime threshold,
// producing debounced levels plus registered rise/fall pulses. Optional input synchronizer: DEBOUNCER_BANK_SYNC_EN.
module debouncer_bank #(
    parameter int                NUM_CH      = 8,
    parameter int                COUNT_WIDTH = 8,
    parameter logic [NUM_CH-1:0] INIT        = '0
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   en,
    input  logic [COUNT_WIDTH-1:0] thresh,
    input  logic [NUM_CH-1:0]      din,
    output logic [NUM_CH-1:0]      dout,
    output logic [NUM_CH-1:0]      rise,
    output logic [NUM_CH-1:0]      fall,
    output logic                   any_event
);

    logic [NUM_CH-1:0]      x;
    logic [NUM_CH-1:0]      s;
    logic [NUM_CH-1:0]      s_next;
    logic [NUM_CH-1:0]      dout_next;
    logic [COUNT_WIDTH-1:0] cnt      [NUM_CH];
    logic [COUNT_WIDTH-1:0] cnt_next [NUM_CH];

`ifdef DEBOUNCER_BANK_SYNC_EN
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;

    // Synchronizer keeps running while en=0 so the filter never sees stale metastable data.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync1 <= INIT;
            sync2 <= INIT;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    assign x = sync2;
`else
    assign x = din;
`endif

    // The counter saturates at thresh, so cnt+1 never exceeds the counter range.
    always_comb begin
        s_next    = s;
        dout_next = dout;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_next[i] = cnt[i];
            if (x[i] != s[i]) begin
                s_next[i]   = x[i];
                cnt_next[i] = '0;
            end else if (cnt[i] >= thresh) begin
                dout_next[i] = s[i];
            end else begin
                cnt_next[i] = cnt[i] + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            s         <= INIT;
            dout      <= INIT;
            rise      <= '0;
            fall      <= '0;
            any_event <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (en) begin
            s         <= s_next;
            dout      <= dout_next;
            cnt       <= cnt_next;
            rise      <= dout_next & ~dout;
            fall      <= dout & ~dout_next;
            any_event <= |(dout_next ^ dout);
        end else begin
            rise      <= '0;
            fall      <= '0;
            any_event <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// Self-checking bench for debouncer_bank: timestamp-based stability model checked every cycle,
// plus directed literal expectations for reset, clean edge, glitch, threshold change, enable freeze, reset mid-count.
module tb_debouncer_bank;

    localparam int         NCH  = 4;
    localparam int         CW   = 8;
    localparam logic [3:0] INIT = 4'b1010;
`ifdef DEBOUNCER_BANK_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic          clk    = 1'b0;
    logic          nrst   = 1'b0;
    logic          en     = 1'b1;
    logic [CW-1:0] thresh = 8'd3;
    logic [3:0]    din    = INIT;
    logic [3:0]    dout;
    logic [3:0]    rise;
    logic [3:0]    fall;
    logic          any_event;

    int tests = 0;
    int fails = 0;
    int rise_total = 0;
    int fall_total = 0;
    int rb;
    int fb;

    debouncer_bank #(.NUM_CH(NCH), .COUNT_WIDTH(CW), .INIT(INIT)) dut (
        .clk(clk), .nrst(nrst), .en(en), .thresh(thresh), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .any_event(any_event)
    );

    always #5 clk = ~clk;

    // Model: a level qualifies once it has been seen unchanged for more than thresh enabled edges
    // since the enabled edge at which it was first sampled.
    int         en_t;
    int         last_chg [4];
    logic [3:0] m_lvl, m_dout, m_rise, m_fall, m_s1, m_s2, mx, prev;

    task automatic model_step();
        if (!nrst) begin
            en_t   = 0;
            m_lvl  = INIT;
            m_dout = INIT;
            m_rise = '0;
            m_fall = '0;
            m_s1   = INIT;
            m_s2   = INIT;
            for (int i = 0; i < 4; i++) last_chg[i] = 0;
        end else begin
            mx     = (SYNC != 0) ? m_s2 : din;
            m_s2   = m_s1;
            m_s1   = din;
            m_rise = '0;
            m_fall = '0;
            if (en) begin
                en_t = en_t + 1;
                prev = m_dout;
                for (int i = 0; i < 4; i++) begin
                    if (mx[i] != m_lvl[i]) begin
                        m_lvl[i]    = mx[i];
                        last_chg[i] = en_t;
                    end else if (en_t - last_chg[i] > int'(thresh)) begin
                        m_dout[i] = m_lvl[i];
                    end
                end
                m_rise = m_dout & ~prev;
                m_fall = prev & ~m_dout;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #2;
            tests++;
            if ({dout, rise, fall, any_event} !== {m_dout, m_rise, m_fall, |(m_rise | m_fall)}) begin
                fails++;
                $display("FAIL cycle_model t=%0t dout=%b/%b rise=%b/%b fall=%b/%b any=%b/%b (got/required)",
                         $time, dout, m_dout, rise, m_rise, fall, m_fall, any_event, |(m_rise | m_fall));
            end
            rise_total += $countones(rise);
            fall_total += $countones(fall);
        end
    endtask

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(3);
        expect_eq("rst_dout", dout, INIT);
        expect_eq("rst_events", {rise, fall, any_event}, 9'd0);
        nrst = 1'b1;
        tick(3);
        expect_eq("post_rst_dout", dout, INIT);
        expect_eq("post_rst_events", {rise, fall, any_event}, 9'd0);

        // Clean edge, thresh=3: qualifies on edge k+4 (+SYNC)
        din = 4'b1011;
        tick(4 + SYNC);
        expect_eq("clean_pre", dout, 4'b1010);
        tick(1);
        expect_eq("clean_dout", dout, 4'b1011);
        expect_eq("clean_rise", rise, 4'b0001);
        expect_eq("clean_any", any_event, 1'b1);
        tick(1);
        expect_eq("clean_rise_end", rise, 4'b0000);

        din = 4'b0000;
        tick(10);
        expect_eq("settle0", dout, 4'b0000);

        // Glitch of 5 samples against thresh=5
        thresh = 8'd5;
        rb = rise_total; fb = fall_total;
        din = 4'b0010;
        tick(5);
        din = 4'b0000;
        tick(12);
        expect_eq("glitch_dout", dout, 4'b0000);
        expect_eq("glitch_pulses", (rise_total - rb) + (fall_total - fb), 0);

        // Threshold lowered mid-count
        thresh = 8'd200;
        rb = rise_total;
        din = 4'b0100;
        tick(10);
        expect_eq("thr_pre", dout, 4'b0000);
        thresh = 8'd4;
        tick(1);
        expect_eq("thr_dout", dout, 4'b0100);
        expect_eq("thr_rise", rise, 4'b0100);
        tick(1);
        expect_eq("thr_rise_count", rise_total - rb, 1);

        // Enable freeze
        thresh = 8'd3;
        din = 4'b0101;
        tick(10);
        expect_eq("frz_settle", dout, 4'b0101);
        din = 4'b0100;
        tick(2);
        en = 1'b0;
        rb = rise_total; fb = fall_total;
        tick(10);
        expect_eq("frz_hold", dout, 4'b0101);
        expect_eq("frz_pulses", (rise_total - rb) + (fall_total - fb), 0);
        en = 1'b1;
        tick(2 + SYNC);
        expect_eq("frz_pre", dout, 4'b0101);
        tick(1);
        expect_eq("frz_fall", fall, 4'b0001);
        expect_eq("frz_dout", dout, 4'b0100);

        // All channels together, thresh=0
        thresh = 8'd0;
        din = 4'b0000;
        tick(4 + SYNC);
        expect_eq("sim_settle", dout, 4'b0000);
        din = 4'b1111;
        tick(1 + SYNC);
        expect_eq("sim_pre", dout, 4'b0000);
        tick(1);
        expect_eq("sim_rise", rise, 4'b1111);
        expect_eq("sim_any", any_event, 1'b1);
        tick(1);
        expect_eq("sim_rise_end", rise, 4'b0000);

        // Reset mid-count, thresh=50
        din = 4'b0000;
        tick(4 + SYNC);
        thresh = 8'd50;
        din = 4'b1111;
        tick(10);
        expect_eq("rmc_pre", dout, 4'b0000);
        nrst = 1'b0;
        din = INIT;
        rb = rise_total; fb = fall_total;
        tick(1);
        expect_eq("rmc_dout", dout, INIT);
        expect_eq("rmc_events", {rise, fall, any_event}, 9'd0);
        nrst = 1'b1;
        tick(60);
        expect_eq("rmc_hold", dout, INIT);
        expect_eq("rmc_pulses", (rise_total - rb) + (fall_total - fb), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debouncer_bank.md
# debouncer_bank

Multi-channel debouncer, the parametrised successor to the single-bit debouncer. It filters NUM_CH independent asynchronous-origin inputs (buttons, switches, GPIO strobes) with a shared, runtime-programmable stability threshold. For each channel it produces a debounced level plus single-cycle rise/fall event pulses. It sits between board I/O pins and the control logic that consumes user-input events.

## Interface
- `NUM_CH`, default 8: number of independent channels (≥1).
- `COUNT_WIDTH`, default 8: width of each per-channel stability counter and of `thresh`.
- `INIT`, default '0 (NUM_CH bits): per-channel reset level of the sample register, the debounced output and (when compiled in) the synchronizer flops. Use 1 for active-low buttons.
- `clk` input 1: sole clock, rising edge.
- `nrst` input 1: reset, synchronous, active-low. Sampled on the rising edge of `clk`.
- `en` input 1: global enable. When 0, all channel state is held and the event outputs are 0.
- `thresh` input COUNT_WIDTH: number of extra stable cycles required. Sampled every cycle and may change at any time.
- `din` input NUM_CH: raw inputs.
- `dout` output NUM_CH: debounced levels.
- `rise` output NUM_CH: 1-cycle pulse when `dout[i]` goes 0→1.
- `fall` output NUM_CH: 1-cycle pulse when `dout[i]` goes 1→0.
- `any_event` output 1: OR of all `rise` and `fall` bits, in the same cycle.

## Operation
- Per channel i the state is: sample `s[i]`, counter `cnt[i]`, output `dout[i]`. Channels are fully independent; there is no cross-channel priority.
- Let `x[i]` be the filtered input: `din[i]`, or the synchronizer output when the synchronizer is compiled in.
- Each rising edge with `nrst`=1 and `en`=1, for each channel:
  - If `x[i]` != `s[i]`: `s[i]` <= `x[i]` and `cnt[i]` <= 0. `dout[i]` is unchanged.
  - Else if `cnt[i]` >= `thresh`: `dout[i]` <= `s[i]`, and `cnt[i]` holds (saturates).
  - Else: `cnt[i]` <= `cnt[i]`+1.
- The `>=` compare makes lowering `thresh` mid-count take effect on the next edge. The counter never wraps.
- `rise[i]` and `fall[i]` are registered. They are 1 in exactly the cycle in which `dout[i]` first shows its new value, and 0 otherwise.
- A glitch shorter than `thresh`+1 stable samples never changes `dout`. A return to the old level before qualification leaves `dout` unchanged and generates no pulse.
- `en`=0: `s`, `cnt` and `dout` hold. `rise`, `fall` and `any_event` are forced 0 on that edge. Counting resumes from the held state when `en` returns to 1.
- Reset (`nrst`=0 at an edge, overriding `en`):
  - `s` <= INIT, `dout` <= INIT, `cnt` <= 0.
  - `rise`, `fall` and `any_event` <= 0.
  - Synchronizer flops <= INIT.
  - Reset mid-count discards progress, and no event is emitted for the resulting level.

## Timing
- Latency without the synchronizer: `x[i]` first sampled at a new value on edge k and held stable. `dout[i]` and the event pulse update on edge k+`thresh`+1.
- `thresh`=0 gives a 1-cycle confirmation: the edge after the change is captured.
- `thresh`=2^COUNT_WIDTH−1 gives the maximum filter, 2^COUNT_WIDTH edges.
- Simultaneous changes on multiple channels qualify independently in the same cycle. `any_event` is asserted once for that cycle.
- A pulse is exactly 1 cycle. The minimum spacing between a rise and a fall on one channel is `thresh`+2 cycles.

## Configuration
- `DEBOUNCER_BANK_SYNC_EN` defined: each `din[i]` passes through a 2-flop synchronizer (reset to INIT[i]) before the filter. All latencies grow by 2 cycles.
- `DEBOUNCER_BANK_SYNC_EN` undefined: `din` feeds the filter directly. The caller guarantees `din` is synchronous to `clk`.

## Test plan
1. **Reset values.** NUM_CH=4, INIT=4'b1010, hold `nrst`=0 for 3 edges, then release. Required: `dout`=4'b1010 and all events 0, both during reset and after release, with `din`=4'b1010 held.
2. **Clean edge.** `thresh`=3, `din[0]` 0→1 at edge k, held. Required:
   - `dout[0]`=1 and `rise[0]`=1 for one cycle at edge k+4 (k+6 with SYNC_EN).
   - `any_event`=1 in that same cycle.
3. **Glitch rejection.** `thresh`=5, `din[1]` high for 5 cycles then low. Required: `dout[1]` stays 0, with no `rise` or `fall` pulse.
4. **Runtime threshold change.** `thresh`=200, `din[2]` 0→1 and held. After 10 edges set `thresh`=4. Required: `dout[2]` goes to 1 on the next edge, with a single `rise[2]` pulse.
5. **Enable freeze.** `thresh`=3, `din[0]` 1→0. Drop `en` for 10 cycles after 2 edges, then raise it. Required:
   - No change to `dout[0]` while `en`=0.
   - `fall[0]` occurs 2 edges after `en` returns.
6. **Simultaneous channels with reset.**
   - All channels toggle together with `thresh`=0. Required: every `rise` bit pulses in the same cycle.
   - Repeat, asserting `nrst` mid-count with `thresh`=50. Required: outputs return to INIT and no pulses are emitted.
